// File: rtl/conv_pkg.sv
// Shared types and dimension constants for the 3x3 convolution engine and its frame scheduler.
package conv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int IMG_W_DEF       = 8;
  localparam int IMG_H_DEF       = 8;
  localparam int KERNEL_SIZE_DEF = 3;
  localparam int DATA_WIDTH_DEF  = 8;

  // Number of valid window origins along one image axis.
  function automatic int out_dim(input int img, input int k);
    return img - k + 1;
  endfunction

  localparam int OUT_W_DEF = out_dim(IMG_W_DEF, KERNEL_SIZE_DEF);
  localparam int OUT_H_DEF = out_dim(IMG_H_DEF, KERNEL_SIZE_DEF);

endpackage

// File: rtl/conv_pos_counter.sv
// Raster-order window-origin counter: column runs fastest, wraps into the next row.
module conv_pos_counter
  import conv_pkg::*;
#(
  parameter int OUT_W = OUT_W_DEF,
  parameter int OUT_H = OUT_H_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_clear,
  input  logic       i_advance,
  output logic [3:0] o_row,
  output logic [3:0] o_col,
  output logic       o_last
);

  localparam logic [3:0] LAST_COL = 4'(OUT_W - 1);
  localparam logic [3:0] LAST_ROW = 4'(OUT_H - 1);

  logic [3:0] r_row;
  logic [3:0] r_col;

  // Row/column registers; the owner never advances past the last origin.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_row <= 4'd0;
      r_col <= 4'd0;
    end else if (i_clear) begin
      r_row <= 4'd0;
      r_col <= 4'd0;
    end else if (i_advance) begin
      if (r_col == LAST_COL) begin
        r_col <= 4'd0;
        r_row <= r_row + 4'd1;
      end else begin
        r_col <= r_col + 4'd1;
      end
    end else begin
      r_row <= r_row;
      r_col <= r_col;
    end
  end

  assign o_row  = r_row;
  assign o_col  = r_col;
  assign o_last = (r_row == LAST_ROW) && (r_col == LAST_COL);

endmodule

// File: rtl/conv_scheduler.sv
// Frame sequencer: issues one engine start per window origin, collects results into the
// output buffer, and guards each engine wait with a watchdog and an abort path.
module conv_scheduler
  import conv_pkg::*;
#(
  parameter int IMG_W          = IMG_W_DEF,
  parameter int IMG_H          = IMG_H_DEF,
  parameter int KERNEL_SIZE    = KERNEL_SIZE_DEF,
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int OUT_ADDR_WIDTH = 6,
  parameter int TIMEOUT        = 64
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_cmd_valid,
  output logic                      o_cmd_ready,
  input  logic                      i_abort,
  output logic                      o_conv_start,
  output logic [3:0]                o_win_row,
  output logic [3:0]                o_win_col,
  input  logic                      i_conv_done,
  input  logic [DATA_WIDTH-1:0]     i_conv_result,
  output logic                      o_wr_en,
  output logic [OUT_ADDR_WIDTH-1:0] o_wr_addr,
  output logic [DATA_WIDTH-1:0]     o_wr_data,
  output logic                      o_busy,
  output logic                      o_frame_done,
  output logic                      o_error
);

  localparam int OUT_W = out_dim(IMG_W, KERNEL_SIZE);
  localparam int OUT_H = out_dim(IMG_H, KERNEL_SIZE);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] WAIT_MAX  = {CNT_W{1'b1}};

  state_t                    r_state;
  logic                      r_conv_start;
  logic                      r_wr_en;
  logic [OUT_ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0]     r_wr_data;
  logic                      r_frame_done;
  logic                      r_error;
  logic [CNT_W-1:0]          r_wait_cnt;

  logic       w_accept;
  logic       w_advance;
  logic       w_last;
  logic [3:0] w_row;
  logic [3:0] w_col;

  assign w_accept  = (r_state == ST_IDLE) && i_cmd_valid;
  assign w_advance = (r_state == ST_WRITE) && !i_abort && !w_last;

  conv_pos_counter #(
    .OUT_W (OUT_W),
    .OUT_H (OUT_H)
  ) u_pos (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (w_accept),
    .i_advance (w_advance),
    .o_row     (w_row),
    .o_col     (w_col),
    .o_last    (w_last)
  );

  // Frame FSM; pulse outputs default low and are raised on the edge entering their state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_conv_start <= 1'b0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_frame_done <= 1'b0;
      r_error      <= 1'b0;
      r_wait_cnt   <= '0;
    end else begin
      r_conv_start <= 1'b0;
      r_wr_en      <= 1'b0;
      r_frame_done <= 1'b0;
      if (i_abort && (r_state != ST_IDLE)) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (i_cmd_valid) begin
              r_state      <= ST_ISSUE;
              r_conv_start <= 1'b1;
              r_wr_addr    <= '0;
              r_error      <= 1'b0;
            end else begin
              r_state <= ST_IDLE;
            end
          end
          ST_ISSUE: begin
            r_state    <= ST_WAIT;
            r_wait_cnt <= '0;
          end
          ST_WAIT: begin
            if (i_conv_done) begin
              r_wr_data <= i_conv_result;
              r_wr_en   <= 1'b1;
              r_state   <= ST_WRITE;
            end else if (r_wait_cnt == WAIT_LAST) begin
              r_error <= 1'b1;
              r_state <= ST_IDLE;
            end else if (r_wait_cnt != WAIT_MAX) begin
              r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            end else begin
              r_wait_cnt <= r_wait_cnt;
            end
          end
          ST_WRITE: begin
            r_wr_addr <= r_wr_addr + OUT_ADDR_WIDTH'(1);
            if (w_last) begin
              r_state      <= ST_DONE;
              r_frame_done <= 1'b1;
            end else begin
              r_state      <= ST_ISSUE;
              r_conv_start <= 1'b1;
            end
          end
          ST_DONE: r_state <= ST_IDLE;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_cmd_ready  = (r_state == ST_IDLE);
  assign o_busy       = (r_state != ST_IDLE);
  assign o_conv_start = r_conv_start;
  assign o_win_row    = w_row;
  assign o_win_col    = w_col;
  assign o_wr_en      = r_wr_en;
  assign o_wr_addr    = r_wr_addr;
  assign o_wr_data    = r_wr_data;
  assign o_frame_done = r_frame_done;
  assign o_error      = r_error;

endmodule
